// File: rtl/alu_pkg.sv
// Shared definitions for the ALU lab datapath blocks.
//   mult_state_t : controller states of the sequential multiplier
//   OP_W         : operand width (matches the 4-bit ripple adder)
//   PROD_W       : product width
//   MULT_ITERS   : add/shift iterations per multiply
package alu_pkg;

    localparam int OP_W       = 4;
    localparam int PROD_W     = 8;
    localparam int MULT_ITERS = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mult_state_t;

endpackage

// File: rtl/shift_add_mult4_if.sv
// Handshake/data bundle for shift_add_mult4.
//   start   : request a multiply (master -> slave)
//   A, B    : multiplicand / multiplier (master -> slave)
//   busy    : iterations in progress (slave -> master)
//   done    : one-cycle pulse, product just became valid (slave -> master)
//   product : A*B, held until the next accepted start (slave -> master)
interface shift_add_mult4_if
    import alu_pkg::*;
    ();

    logic              start;
    logic [OP_W-1:0]   A;
    logic [OP_W-1:0]   B;
    logic              busy;
    logic              done;
    logic [PROD_W-1:0] product;

    modport master (
        output start, A, B,
        input  busy, done, product
    );

    modport slave (
        input  start, A, B,
        output busy, done, product
    );

endinterface

// File: rtl/shift_add_mult4_adder.sv
// Adder4bit: 4-bit ripple-carry adder, the only arithmetic element of the
// multiplier datapath.
//   A, B : addends
//   Cin  : carry in
//   Sum  : A + B + Cin, low 4 bits
//   Cout : carry out of bit 3
module Adder4bit
    import alu_pkg::*;
(
    input  logic [OP_W-1:0] A,
    input  logic [OP_W-1:0] B,
    input  logic            Cin,
    output logic [OP_W-1:0] Sum,
    output logic            Cout
);

    logic [OP_W:0] carry;

    assign carry[0] = Cin;

    generate
        for (genvar gi = 0; gi < OP_W; gi++) begin : g_fa
            assign Sum[gi]       = A[gi] ^ B[gi] ^ carry[gi];
            assign carry[gi + 1] = (A[gi] & B[gi]) | (carry[gi] & (A[gi] ^ B[gi]));
        end
    endgenerate

    assign Cout = carry[OP_W];

endmodule

// File: rtl/shift_add_mult4.sv
// shift_add_mult4: sequential 4x4 unsigned shift-and-add multiplier.
// Each CALC cycle adds M (when Q[0] is set) into the accumulator P_hi through
// Adder4bit and shifts {Cout, Sum, Q} right by one. Four iterations per
// multiply; done pulses for one cycle when the product is ready.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : slave side of shift_add_mult4_if (start, A, B, busy, done, product)
module shift_add_mult4
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    shift_add_mult4_if.slave bus
);

    localparam logic [1:0] LAST_ITER = 2'(MULT_ITERS - 1);

    mult_state_t     state_reg, state_next;
    logic [OP_W-1:0] m_reg, m_next;
    logic [OP_W-1:0] p_hi_reg, p_hi_next;
    logic [OP_W-1:0] q_reg, q_next;
    logic [1:0]      cnt_reg, cnt_next;

    logic [OP_W-1:0] add_b;
    logic [OP_W-1:0] sum;
    logic            cout;

    // Partial product term: multiplicand gated by the current multiplier LSB.
    assign add_b = q_reg[0] ? m_reg : '0;

    Adder4bit u_adder (
        .A    (p_hi_reg),
        .B    (add_b),
        .Cin  (1'b0),
        .Sum  (sum),
        .Cout (cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            m_reg     <= '0;
            p_hi_reg  <= '0;
            q_reg     <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            m_reg     <= m_next;
            p_hi_reg  <= p_hi_next;
            q_reg     <= q_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        m_next     = m_reg;
        p_hi_next  = p_hi_reg;
        q_next     = q_reg;
        cnt_next   = cnt_reg;

        case (state_reg)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_next = CALC;
                    m_next     = bus.A;
                    q_next     = bus.B;
                    p_hi_next  = '0;
                    cnt_next   = '0;
                end else if (state_reg == DONE) begin
                    state_next = IDLE;
                end
            end
            CALC: begin
                // Carry out becomes the new MSB, so nothing is ever lost.
                p_hi_next = {cout, sum[OP_W-1:1]};
                q_next    = {sum[0], q_reg[OP_W-1:1]};
                cnt_next  = cnt_reg + 2'd1;
                if (cnt_reg == LAST_ITER) begin
                    state_next = DONE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.busy    = (state_reg == CALC);
    assign bus.done    = (state_reg == DONE);
    assign bus.product = {p_hi_reg, q_reg};

endmodule

// File: tb/tb_shift_add_mult4.sv
// Self-checking bench for shift_add_mult4. A reference model at the clock edge
// decides which starts are accepted (a start is taken when at least five edges
// have passed since the previous accept) and queues A*B; a monitor on the
// falling edge checks busy/done timing, pops the queue on done and checks the
// product, and checks that the product holds while idle.
module tb_shift_add_mult4;

    logic clk;
    logic rst;

    shift_add_mult4_if bus ();

    shift_add_mult4 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [7:0] prod;
        int         acc;
    } exp_t;

    exp_t sb[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_acc = -1000;
    bit model_on = 0;
    bit last_rst = 0;
    logic [7:0] hold = 8'h00;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=0x%0h expected=0x%0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: acceptance and expected results per rising edge.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            last_rst = rst;
            if (rst) begin
                model_on = 1;
                last_acc = -1000;
                sb.delete();
            end else if (bus.start && (cyc - last_acc >= 5)) begin
                last_acc = cyc;
                sb.push_back('{prod: 8'(int'(bus.A) * int'(bus.B)), acc: cyc});
            end
        end
    end

    // Monitor / scoreboard checker.
    initial begin
        exp_t e;
        int   d;
        forever begin
            @(negedge clk);
            if (model_on) begin
                if (last_rst) hold = 8'h00;
                d = cyc - last_acc;
                chk("busy", int'(bus.busy), int'(d >= 0 && d <= 3));
                chk("done", int'(bus.done), int'(d == 4));
                if (bus.done) begin
                    if (sb.size() == 0) begin
                        chk("spurious_done", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("product", int'(bus.product), int'(e.prod));
                        chk("latency", cyc - e.acc, 4);
                        $display("mult accept=%0d done=%0d product=0x%02h expected=0x%02h",
                                 e.acc, cyc, bus.product, e.prod);
                        hold = e.prod;
                    end
                end else if (!bus.busy) begin
                    chk("product_hold", int'(bus.product), int'(hold));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one edge, then wait until the DONE cycle.
    task automatic mult(input logic [3:0] a, input logic [3:0] b);
        bus.start = 1'b1;
        bus.A     = a;
        bus.B     = b;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.A     = 4'h0;
        bus.B     = 4'h0;
        repeat (2) tick();
        rst = 1'b0;
        repeat (10) tick();

        // Directed products.
        mult(4'hF, 4'hF);
        mult(4'hB, 4'h4);
        mult(4'h0, 4'h9);
        mult(4'h9, 4'h1);
        repeat (3) tick();

        // Start while busy is ignored.
        bus.start = 1'b1; bus.A = 4'h3; bus.B = 4'h5;
        tick();
        bus.start = 1'b0;
        tick();
        bus.start = 1'b1; bus.A = 4'hF; bus.B = 4'hF;
        tick();
        bus.start = 1'b0;
        repeat (5) tick();

        // Back-to-back with start held high.
        bus.start = 1'b1; bus.A = 4'h7; bus.B = 4'h6;
        repeat (5) tick();
        bus.A = 4'hA; bus.B = 4'hC;
        tick();
        bus.start = 1'b0;
        repeat (6) tick();

        // Reset in the middle of an operation.
        bus.start = 1'b1; bus.A = 4'hD; bus.B = 4'hE;
        tick();
        bus.start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (8) tick();
        mult(4'h2, 4'h3);
        repeat (2) tick();

        // Exhaustive sweep.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                mult(4'(a), 4'(b));
            end
        end
        repeat (2) tick();

        // Random start/operand traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            bus.start = 1'($urandom_range(0, 1));
            bus.A     = 4'($urandom);
            bus.B     = 4'($urandom);
            rst       = ($urandom_range(0, 59) == 0);
            tick();
        end
        bus.start = 1'b0;
        rst       = 1'b0;
        repeat (8) tick();

        chk("drain", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
